// File: rtl/pio_mux_irq.sv
// Pin multiplexer with synchronised, glitch-filtered pin inputs and latched edge interrupts.
// Pads are resolved to tristate at the top level from oPIN_OE/oPIN_OUT.
module pio_mux_irq #(
    parameter int pPINS   = 32,
    parameter int pMSEL_W = 2,
    parameter int pFILT_W = 4
) (
    input  logic                                    iCLK,
    input  logic                                    iRESETn,
    input  logic [pPINS-1:0]                        iPIN_IN,
    output logic [pPINS-1:0]                        oPIN_OUT,
    output logic [pPINS-1:0]                        oPIN_OE,
    input  logic [pPINS-1:0]                        iPIO_OUT,
    input  logic [pPINS-1:0]                        iPIO_DIR,
    input  logic [pPINS*pMSEL_W-1:0]                iMSEL,
    input  logic [pPINS*((2**pMSEL_W)-1)-1:0]       iALT_OUT,
    input  logic [pPINS*((2**pMSEL_W)-1)-1:0]       iALT_OE,
    input  logic [pFILT_W-1:0]                      iFILT_LEN,
    output logic [pPINS-1:0]                        oPIO_IN,
    input  logic [pPINS-1:0]                        iIRQ_RISE_EN,
    input  logic [pPINS-1:0]                        iIRQ_FALL_EN,
    input  logic [pPINS-1:0]                        iIRQ_CLR,
    output logic [pPINS-1:0]                        oIRQ_STATUS,
    output logic                                    oIRQ
);

    localparam int pSLOTS = (2**pMSEL_W) - 1;

    logic [pPINS-1:0]   sync1;
    logic [pPINS-1:0]   sync2;
    logic [pPINS-1:0]   filt;
    logic [pPINS-1:0]   prev;
    logic [pFILT_W-1:0] cnt [pPINS];
    logic [pPINS-1:0]   rise;
    logic [pPINS-1:0]   fall;
    logic [pPINS-1:0]   setEvt;
    logic [pPINS-1:0]   oeNext;
    logic [pPINS-1:0]   outNext;
    logic [pMSEL_W-1:0] sel;

    // Filter: f follows s2 only after s2 has disagreed for more than L samples.
    // Using >= rather than == keeps a shortened L from letting the count run past it.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            prev  <= '0;
            for (int i = 0; i < pPINS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= iPIN_IN;
            sync2 <= sync1;
            prev  <= filt;
            for (int i = 0; i < pPINS; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] >= iFILT_LEN) begin
                    filt[i] <= ~filt[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + pFILT_W'(1);
                end
            end
        end
    end

    assign oPIO_IN = filt;
    assign rise    = filt & ~prev;
    assign fall    = ~filt & prev;
    assign setEvt  = (rise & iIRQ_RISE_EN) | (fall & iIRQ_FALL_EN);

    // A set event in the same cycle as a clear keeps the bit set.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oIRQ_STATUS <= '0;
            oIRQ        <= 1'b0;
        end else begin
            oIRQ_STATUS <= (oIRQ_STATUS & ~iIRQ_CLR) | setEvt;
            oIRQ        <= |oIRQ_STATUS;
        end
    end

    always_comb begin
        oeNext  = '0;
        outNext = '0;
        sel     = '0;
        for (int i = 0; i < pPINS; i++) begin
            sel = iMSEL[i*pMSEL_W +: pMSEL_W];
            if (sel == '0) begin
                oeNext[i]  = iPIO_DIR[i];
                outNext[i] = iPIO_OUT[i];
            end
            for (int k = 1; k <= pSLOTS; k++) begin
                if (sel == pMSEL_W'(k)) begin
                    oeNext[i]  = iALT_OE[(k-1)*pPINS + i];
                    outNext[i] = iALT_OUT[(k-1)*pPINS + i];
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            oPIN_OE  <= '0;
            oPIN_OUT <= '0;
        end else begin
            oPIN_OE  <= oeNext;
            oPIN_OUT <= outNext & oeNext;
        end
    end

endmodule

// File: tb/tb_pio_mux_irq.sv
// Directed bench for pio_mux_irq: a reference model checked every cycle plus
// hand-computed expectations at the points of interest.
module tb_pio_mux_irq;

    logic        iCLK = 1'b0;
    logic        iRESETn;
    logic [31:0] iPIN_IN, oPIN_OUT, oPIN_OE, iPIO_OUT, iPIO_DIR;
    logic [63:0] iMSEL;
    logic [95:0] iALT_OUT, iALT_OE;
    logic [3:0]  iFILT_LEN;
    logic [31:0] oPIO_IN, iIRQ_RISE_EN, iIRQ_FALL_EN, iIRQ_CLR, oIRQ_STATUS;
    logic        oIRQ;

    // Narrow build: 8 pins, 8 sources per pin.
    logic [7:0]  bPIN_OUT, bPIN_OE, bPIO_IN, bIRQ_STATUS;
    logic [23:0] bMSEL;
    logic [55:0] bALT_OUT, bALT_OE;
    logic        bIRQ;

    int nCmp = 0;
    int nBad = 0;

    pio_mux_irq dut (
        .iCLK(iCLK), .iRESETn(iRESETn), .iPIN_IN(iPIN_IN),
        .oPIN_OUT(oPIN_OUT), .oPIN_OE(oPIN_OE),
        .iPIO_OUT(iPIO_OUT), .iPIO_DIR(iPIO_DIR), .iMSEL(iMSEL),
        .iALT_OUT(iALT_OUT), .iALT_OE(iALT_OE), .iFILT_LEN(iFILT_LEN),
        .oPIO_IN(oPIO_IN), .iIRQ_RISE_EN(iIRQ_RISE_EN), .iIRQ_FALL_EN(iIRQ_FALL_EN),
        .iIRQ_CLR(iIRQ_CLR), .oIRQ_STATUS(oIRQ_STATUS), .oIRQ(oIRQ)
    );

    pio_mux_irq #(.pPINS(8), .pMSEL_W(3), .pFILT_W(4)) dutNarrow (
        .iCLK(iCLK), .iRESETn(iRESETn), .iPIN_IN(8'h00),
        .oPIN_OUT(bPIN_OUT), .oPIN_OE(bPIN_OE),
        .iPIO_OUT(8'h00), .iPIO_DIR(8'h00), .iMSEL(bMSEL),
        .iALT_OUT(bALT_OUT), .iALT_OE(bALT_OE), .iFILT_LEN(4'd0),
        .oPIO_IN(bPIO_IN), .iIRQ_RISE_EN(8'h00), .iIRQ_FALL_EN(8'h00),
        .iIRQ_CLR(8'h00), .oIRQ_STATUS(bIRQ_STATUS), .oIRQ(bIRQ)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLK = ~iCLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Pad level reaches the filter input after two samples; the filtered level
    // flips once the input has disagreed with it for more than L consecutive samples.
    logic [31:0] mS1, mS2, mF, mP, mStat;
    logic        mIrq;
    int          mRun [32];
    logic [63:0] expQ [$];

    function automatic logic [63:0] muxExp(input logic [63:0] msel, input logic [95:0] aOut,
                                           input logic [95:0] aOe, input logic [31:0] dir,
                                           input logic [31:0] pOut);
        logic [31:0] oe;
        logic [31:0] out;
        int src;
        oe  = '0;
        out = '0;
        for (int i = 0; i < 32; i++) begin
            src = int'(msel[i*2 +: 2]);
            if (src == 0) begin
                oe[i]  = dir[i];
                out[i] = pOut[i];
            end else begin
                oe[i]  = aOe[(src-1)*32 + i];
                out[i] = aOut[(src-1)*32 + i];
            end
            out[i] = out[i] & oe[i];
        end
        return {oe, out};
    endfunction

    always @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            mS1 <= '0; mS2 <= '0; mF <= '0; mP <= '0; mStat <= '0; mIrq <= 1'b0;
            for (int i = 0; i < 32; i++) mRun[i] <= 0;
            expQ.delete();
        end else begin
            mS1 <= iPIN_IN;
            mS2 <= mS1;
            for (int i = 0; i < 32; i++) begin
                if (mS2[i] != mF[i]) begin
                    if (mRun[i] + 1 > int'(iFILT_LEN)) begin
                        mF[i]   <= ~mF[i];
                        mRun[i] <= 0;
                    end else begin
                        mRun[i] <= mRun[i] + 1;
                    end
                end else begin
                    mRun[i] <= 0;
                end
            end
            mP    <= mF;
            mStat <= (mStat & ~iIRQ_CLR) | (mF & ~mP & iIRQ_RISE_EN) | (~mF & mP & iIRQ_FALL_EN);
            mIrq  <= (mStat != 32'h0);
            expQ.push_back(muxExp(iMSEL, iALT_OUT, iALT_OE, iPIO_DIR, iPIO_OUT));
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        nCmp++;
        if (act !== want) begin
            nBad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    always @(negedge iCLK) begin
        logic [63:0] mux;
        mux = '0;
        if (expQ.size() > 0) mux = expQ.pop_front();
        check("model_pio_in", 64'(oPIO_IN), 64'(mF));
        check("model_status", 64'(oIRQ_STATUS), 64'(mStat));
        check("model_irq", 64'(oIRQ), 64'(mIrq));
        check("model_pin", {oPIN_OE, oPIN_OUT}, mux);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_pio_in"}, 64'(oPIO_IN), 64'h0);
        check({name, "_status"}, 64'(oIRQ_STATUS), 64'h0);
        check({name, "_irq"}, 64'(oIRQ), 64'h0);
        check({name, "_oe"}, 64'(oPIN_OE), 64'h0);
        check({name, "_out"}, 64'(oPIN_OUT), 64'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        iRESETn = 1'b0;
        iPIN_IN = '0; iPIO_OUT = '0; iPIO_DIR = '0; iMSEL = '0;
        iALT_OUT = '0; iALT_OE = '0; iFILT_LEN = '0;
        iIRQ_RISE_EN = '0; iIRQ_FALL_EN = '0; iIRQ_CLR = '0;
        bMSEL = '0; bALT_OUT = '0; bALT_OE = '0;
        tick(3);
        check_all_zero("reset");
        iRESETn = 1'b1;
        tick(2);

        // L=0: pad rise on pin 3, latency 3 / status 4 / irq 5 edges.
        iIRQ_RISE_EN = 32'h8;
        iPIN_IN[3] = 1'b1;
        tick(2); check("l0_pin3_e2", 64'(oPIO_IN[3]), 64'h0);
        tick(1); check("l0_pin3_e3", 64'(oPIO_IN[3]), 64'h1);
                 check("l0_stat3_e3", 64'(oIRQ_STATUS[3]), 64'h0);
        tick(1); check("l0_stat3_e4", 64'(oIRQ_STATUS[3]), 64'h1);
                 check("l0_irq_e4", 64'(oIRQ), 64'h0);
        tick(1); check("l0_irq_e5", 64'(oIRQ), 64'h1);
        iIRQ_CLR = 32'h8;
        tick(1); iIRQ_CLR = '0;
        check("clr3_stat", 64'(oIRQ_STATUS[3]), 64'h0);
        check("clr3_irq_lag", 64'(oIRQ), 64'h1);
        tick(1); check("clr3_irq", 64'(oIRQ), 64'h0);
        iPIN_IN[3] = 1'b0;
        iIRQ_RISE_EN = '0;
        tick(5);

        // L=4: a 3-cycle glitch is rejected, a 6-cycle pulse passes after 7 edges.
        iFILT_LEN = 4'd4;
        iIRQ_RISE_EN = 32'h1;
        iPIN_IN[0] = 1'b1;
        tick(3); iPIN_IN[0] = 1'b0;
        tick(12);
        check("glitch_pin0", 64'(oPIO_IN[0]), 64'h0);
        check("glitch_stat0", 64'(oIRQ_STATUS[0]), 64'h0);
        iPIN_IN[0] = 1'b1;
        tick(6); check("pulse_pin0_e6", 64'(oPIO_IN[0]), 64'h0);
        iPIN_IN[0] = 1'b0;
        tick(1); check("pulse_pin0_e7", 64'(oPIO_IN[0]), 64'h1);
        tick(1); check("pulse_stat0", 64'(oIRQ_STATUS[0]), 64'h1);
        tick(12); check("pulse_pin0_low", 64'(oPIO_IN[0]), 64'h0);
        iIRQ_CLR = '1;
        tick(1); iIRQ_CLR = '0;
        iIRQ_RISE_EN = '0;
        tick(2);
        check("pulse_cleared", 64'(oIRQ_STATUS), 64'h0);

        // Fall on pin 5 coincident with a clear: the set wins.
        iFILT_LEN = 4'd0;
        iIRQ_FALL_EN = 32'h20;
        iPIN_IN[5] = 1'b1;
        tick(6);
        check("fall5_high", 64'(oPIO_IN[5]), 64'h1);
        check("fall5_no_stat", 64'(oIRQ_STATUS), 64'h0);
        iPIN_IN[5] = 1'b0;
        tick(3); iIRQ_CLR = 32'h20;
        tick(1); iIRQ_CLR = '0;
        check("fall5_set_wins", 64'(oIRQ_STATUS[5]), 64'h1);
        tick(1); check("fall5_irq", 64'(oIRQ), 64'h1);
        iIRQ_CLR = 32'h20;
        tick(1); iIRQ_CLR = '0;
        check("fall5_cleared", 64'(oIRQ_STATUS[5]), 64'h0);
        check("fall5_irq_lag", 64'(oIRQ), 64'h1);
        tick(1); check("fall5_irq_drop", 64'(oIRQ), 64'h0);
        iIRQ_FALL_EN = '0;

        // Output mux on pin 7.
        iPIO_OUT[7] = 1'b1; iPIO_DIR[7] = 1'b0;
        tick(1);
        check("mux7_pio_oe", 64'(oPIN_OE[7]), 64'h0);
        check("mux7_pio_out", 64'(oPIN_OUT[7]), 64'h0);
        iMSEL[15:14] = 2'd2; iALT_OE[39] = 1'b1; iALT_OUT[39] = 1'b1;
        #1 check("mux7_latency", 64'(oPIN_OE[7]), 64'h0);
        tick(1);
        check("mux7_alt2_oe", 64'(oPIN_OE[7]), 64'h1);
        check("mux7_alt2_out", 64'(oPIN_OUT[7]), 64'h1);
        iALT_OE[39] = 1'b0;
        tick(1);
        check("mux7_forced_out", 64'(oPIN_OUT[7]), 64'h0);
        iMSEL[15:14] = 2'd0; iPIO_DIR[7] = 1'b1;
        tick(1);
        check("mux7_pio_drive", 64'({oPIN_OE[7], oPIN_OUT[7]}), 64'h3);

        // Narrow build: slot 7 of pin 0 sits at bit 6*8+0.
        bMSEL[2:0] = 3'd7;
        bALT_OE[48] = 1'b1; bALT_OUT[48] = 1'b1;
        bALT_OE[0] = 1'b0;  bALT_OUT[0] = 1'b1;
        bALT_OE[40] = 1'b1; bALT_OUT[40] = 1'b0;
        tick(1);
        check("narrow_slot7", 64'({bPIN_OE[0], bPIN_OUT[0]}), 64'h3);
        bALT_OE[0] = 1'b1; bALT_OE[40] = 1'b0; bALT_OUT[40] = 1'b1;
        tick(1);
        check("narrow_unselected", 64'({bPIN_OE[0], bPIN_OUT[0]}), 64'h3);
        bALT_OUT[48] = 1'b0;
        tick(1);
        check("narrow_slot7_low", 64'({bPIN_OE[0], bPIN_OUT[0]}), 64'h2);

        // Reset mid-count with a pending interrupt clears outputs without a clock.
        iFILT_LEN = 4'd4;
        iIRQ_RISE_EN = 32'h2;
        iPIN_IN[1] = 1'b1;
        tick(10);
        check("pre_reset_irq", 64'(oIRQ), 64'h1);
        iPIN_IN[2] = 1'b1;
        tick(4);
        #2 iRESETn = 1'b0;
        #1 check_all_zero("async_reset");
        iPIN_IN = '0;
        tick(2);
        iRESETn = 1'b1;
        tick(10);
        check("post_reset_status", 64'(oIRQ_STATUS), 64'h0);
        check("post_reset_irq", 64'(oIRQ), 64'h0);
        check("post_reset_pio_in", 64'(oPIO_IN), 64'h0);

        // Pad already high at reset release raises a single rise event.
        iRESETn = 1'b0;
        iPIN_IN[4] = 1'b1;
        iIRQ_RISE_EN = 32'h10;
        iFILT_LEN = 4'd0;
        tick(2);
        iRESETn = 1'b1;
        tick(2); check("rel_pin4_e2", 64'(oPIO_IN[4]), 64'h0);
        tick(1); check("rel_pin4_e3", 64'(oPIO_IN[4]), 64'h1);
        tick(1); check("rel_stat4", 64'(oIRQ_STATUS), 64'h10);
        iIRQ_RISE_EN = '0;
        tick(3); check("sticky_stat4", 64'(oIRQ_STATUS), 64'h10);
        iIRQ_CLR = 32'h10;
        tick(1); iIRQ_CLR = '0;
        check("sticky_cleared", 64'(oIRQ_STATUS), 64'h0);

        // Shortening L mid-count takes effect on the next comparison.
        iFILT_LEN = 4'd8;
        iPIN_IN[6] = 1'b1;
        tick(5); check("lchg_pin6_e5", 64'(oPIO_IN[6]), 64'h0);
        iFILT_LEN = 4'd2;
        tick(1); check("lchg_pin6_e6", 64'(oPIO_IN[6]), 64'h1);
        tick(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
